// File: rtl/clk_div_multi_if.sv
// Configuration bus for clk_div_multi: a one-cycle write strobe carrying
// target channel, period and high time, plus the registered reject pulse.
interface clk_div_multi_if #(
  parameter int CH    = 2,
  parameter int CNT_W = 28
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_period,
    output cfg_high,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_high,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/strobe divider.
// Each channel counts 0..per-1 while enabled, drives clk_out high for the
// first 'high' cycles of every period and pulses tick on the first cycle.
// Writes to a running channel are parked in a shadow copy and only take
// effect at a reload edge, so a period in progress is never cut or stretched.
module clk_div_multi #(
  parameter int CH         = 2,
  parameter int CNT_W      = 28,
  parameter int DEF_PERIOD = 27000,
  parameter int DEF_HIGH   = 13500
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  en,
  clk_div_multi_if.slave cfg,
  output logic [CH-1:0]  clk_out,
  output logic [CH-1:0]  tick
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  // live state
  logic [CNT_W-1:0] cnt     [CH];
  logic [CNT_W-1:0] per     [CH];
  logic [CNT_W-1:0] high    [CH];
  logic [CNT_W-1:0] sh_per  [CH];
  logic [CNT_W-1:0] sh_high [CH];
  logic [CH-1:0]    active;
  logic [CH-1:0]    pend;

  // next-state values
  logic [CNT_W-1:0] cnt_nx     [CH];
  logic [CNT_W-1:0] per_nx     [CH];
  logic [CNT_W-1:0] high_nx    [CH];
  logic [CNT_W-1:0] sh_per_nx  [CH];
  logic [CNT_W-1:0] sh_high_nx [CH];
  logic [CH-1:0]    active_nx;
  logic [CH-1:0]    pend_nx;
  logic [CH-1:0]    out_nx;
  logic [CH-1:0]    tick_nx;
  logic             cfg_ok;
  logic             err_nx;

  // Per-channel counting, reload/apply of pending config and write routing.
  always_comb begin : next_state
    logic [CNT_W-1:0] eff_high;
    logic             hit;
    cfg_ok = cfg.cfg_we
           && (32'(cfg.cfg_ch) < 32'(CH))
           && (cfg.cfg_period >= CNT_W'(2))
           && (cfg.cfg_high <= cfg.cfg_period);
    err_nx = cfg.cfg_we && !cfg_ok;
    for (int i = 0; i < CH; i++) begin
      eff_high      = high[i];
      hit           = cfg_ok && (cfg.cfg_ch == CH_W'(i));
      cnt_nx[i]     = cnt[i];
      per_nx[i]     = per[i];
      high_nx[i]    = high[i];
      sh_per_nx[i]  = sh_per[i];
      sh_high_nx[i] = sh_high[i];
      active_nx[i]  = active[i];
      pend_nx[i]    = pend[i];
      out_nx[i]     = 1'b0;
      tick_nx[i]    = 1'b0;

      if (!en[i]) begin
        // disabling truncates the period at once
        cnt_nx[i]    = '0;
        active_nx[i] = 1'b0;
      end else if (!active[i] || (cnt[i] == per[i] - CNT_W'(1))) begin
        // period start: pick up any parked config before deriving outputs
        cnt_nx[i]    = '0;
        active_nx[i] = 1'b1;
        if (pend[i]) begin
          per_nx[i]  = sh_per[i];
          high_nx[i] = sh_high[i];
          eff_high   = sh_high[i];
          pend_nx[i] = 1'b0;
        end else begin
          eff_high   = high[i];
        end
        out_nx[i]  = (eff_high != '0);
        tick_nx[i] = 1'b1;
      end else begin
        cnt_nx[i] = cnt[i] + CNT_W'(1);
        out_nx[i] = (cnt_nx[i] < high[i]);
      end

      // A write sampled on a reload edge lands after the apply above, so it
      // waits for the following reload.
      if (hit) begin
        if (!active[i] && !en[i]) begin
          per_nx[i]  = cfg.cfg_period;
          high_nx[i] = cfg.cfg_high;
          pend_nx[i] = 1'b0;
        end else begin
          sh_per_nx[i]  = cfg.cfg_period;
          sh_high_nx[i] = cfg.cfg_high;
          pend_nx[i]    = 1'b1;
        end
      end else begin
        pend_nx[i] = pend_nx[i];
      end
    end
  end

  // State and output registers with synchronous reset to the default rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i]     <= '0;
        per[i]     <= CNT_W'(DEF_PERIOD);
        high[i]    <= CNT_W'(DEF_HIGH);
        sh_per[i]  <= CNT_W'(DEF_PERIOD);
        sh_high[i] <= CNT_W'(DEF_HIGH);
      end
      active      <= '0;
      pend        <= '0;
      clk_out     <= '0;
      tick        <= '0;
      cfg.cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt[i]     <= cnt_nx[i];
        per[i]     <= per_nx[i];
        high[i]    <= high_nx[i];
        sh_per[i]  <= sh_per_nx[i];
        sh_high[i] <= sh_high_nx[i];
      end
      active      <= active_nx;
      pend        <= pend_nx;
      clk_out     <= out_nx;
      tick        <= tick_nx;
      cfg.cfg_err <= err_nx;
    end
  end
endmodule
